// File: rtl/data_mem_responder.sv
// Data-memory target for the CPU load/store port: one request at a time over valid/ready,
// LATENCY wait states, RV32I byte-lane merge on stores and sign/zero extension on loads.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit FAST = (LATENCY == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we, r_err, r_rsp_err;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept, w_commit;
  logic        w_c_we, w_c_err;
  logic [2:0]  w_c_funct3;
  logic [31:0] w_c_addr, w_c_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rd_word, w_rd_shift, w_load, w_wdata_lane;
  logic [3:0]  w_be;

  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr[0];
      3'b010:  bad = |addr[1:0];
      3'b100:  bad = we;
      3'b101:  bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    // Full-width compare: addresses past the array never alias back into it.
    if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
    return bad;
  endfunction

  assign w_accept = (r_state == S_IDLE) && req_valid && !reset;

  // With zero latency the access happens on the accept edge straight from the inputs.
  assign w_commit   = FAST ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd0) && !reset);
  assign w_c_we     = FAST ? req_we     : r_we;
  assign w_c_funct3 = FAST ? req_funct3 : r_funct3;
  assign w_c_addr   = FAST ? req_addr   : r_addr;
  assign w_c_wdata  = FAST ? req_wdata  : r_wdata;
  assign w_c_err    = FAST ? access_err(req_we, req_funct3, req_addr) : r_err;

  assign w_idx      = w_c_addr[AW+1:2];
  assign w_rd_word  = r_mem[w_idx];
  assign w_rd_shift = w_rd_word >> {w_c_addr[1:0], 3'b000};

  always_comb begin
    w_load       = 32'd0;
    w_be         = 4'b0000;
    w_wdata_lane = w_c_wdata;
    case (w_c_funct3)
      3'b000: begin
        w_load       = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
        w_be         = 4'b0001 << w_c_addr[1:0];
        w_wdata_lane = {4{w_c_wdata[7:0]}};
      end
      3'b001: begin
        w_load       = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
        w_be         = 4'b0011 << w_c_addr[1:0];
        w_wdata_lane = {2{w_c_wdata[15:0]}};
      end
      3'b010: begin
        w_load = w_rd_word;
        w_be   = 4'b1111;
      end
      3'b100:  w_load = {24'd0, w_rd_shift[7:0]};
      3'b101:  w_load = {16'd0, w_rd_shift[15:0]};
      default: w_load = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_state_nxt = FAST ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= access_err(req_we, req_funct3, req_addr);
        r_cnt    <= 4'(LATENCY);
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rsp_err <= w_c_err;
        r_rdata   <= (w_c_err || w_c_we) ? 32'd0 : w_load;
      end
    end
  end

  // NOTE: the array has no reset branch; its contents survive reset and it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (w_commit && w_c_we && !w_c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
      end
    end
  end

  assign req_ready = (r_state == S_IDLE) && !reset;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency, lane merge/extension, error decode,
// response backpressure and reset in the middle of a store.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for its response, optionally hold rsp_ready low for
  // 'hold' extra cycles while checking that the response stays put.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hA5A5_A5A5; req_wdata = 32'h5A5A_5A5A; req_funct3 = 3'b111;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_err",   32'(rsp_err),   32'd0);
    check("rst_rdata", rsp_rdata,      32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
    check("sw_latency", 32'(lat), 32'd3);
    check("sw_err",     32'(er),  32'd0);
    check("sw_rdata",   rd,       32'd0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
    check("lw_rdata",   rd,       32'hDEAD_BEEF);
    check("lw_err",     32'(er),  32'd0);
    check("lw_latency", 32'(lat), 32'd3);

    txn(1'b1, 3'b000, 32'h13, 32'hAAAA_AA80, 0, rd, er, lat);
    check("sb_err", 32'(er), 32'd0);
    txn(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er, lat);
    check("lb_sext", rd, 32'hFFFF_FF80);
    txn(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er, lat);
    check("lbu_zext", rd, 32'h0000_0080);
    txn(1'b1, 3'b001, 32'h10, 32'h5555_1234, 0, rd, er, lat);
    check("sh_err", 32'(er), 32'd0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
    check("merge_lw", rd, 32'h80AD_1234);
    txn(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er, lat);
    check("lh_sext", rd, 32'hFFFF_80AD);
    txn(1'b0, 3'b101, 32'h12, 32'h0, 0, rd, er, lat);
    check("lhu_zext", rd, 32'h0000_80AD);
    txn(1'b0, 3'b000, 32'h11, 32'h0, 0, rd, er, lat);
    check("lb_lane1", rd, 32'h0000_0012);

    txn(1'b0, 3'b010, 32'h12, 32'h0, 0, rd, er, lat);
    check("lw_misal_err",   32'(er), 32'd1);
    check("lw_misal_rdata", rd,      32'd0);
    txn(1'b1, 3'b001, 32'h11, 32'hFFFF_FFFF, 0, rd, er, lat);
    check("sh_misal_err", 32'(er), 32'd1);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
    check("sh_misal_nowrite", rd, 32'h80AD_1234);
    txn(1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er, lat);
    check("ld_f3_011_err",   32'(er), 32'd1);
    check("ld_f3_011_rdata", rd,      32'd0);
    txn(1'b1, 3'b100, 32'h10, 32'h0, 0, rd, er, lat);
    check("st_f3_100_err", 32'(er), 32'd1);
    txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
    check("st_f3_nowrite", rd, 32'h80AD_1234);
    txn(1'b0, 3'b010, 32'h1000, 32'h0, 0, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    txn(1'b0, 3'b010, 32'h0001_0010, 32'h0, 0, rd, er, lat);
    check("oor_nowrap_err", 32'(er), 32'd1);
    txn(1'b1, 3'b000, 32'h0FFF, 32'h0000_005A, 0, rd, er, lat);
    check("sb_top_err", 32'(er), 32'd0);
    txn(1'b0, 3'b100, 32'h0FFF, 32'h0, 0, rd, er, lat);
    check("lbu_top", rd, 32'h0000_005A);

    txn(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er, lat);
    check("bp_rdata", rd, 32'h80AD_1234);
    check("bp_ready_after", 32'(req_ready), 32'd1);
    check("bp_valid_after", 32'(rsp_valid), 32'd0);

    txn(1'b1, 3'b010, 32'h20, 32'h1111_1111, 0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_wait_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abandon_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    check("abandon_ready", 32'(req_ready), 32'd1);
    txn(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er, lat);
    check("abandon_nowrite", rd, 32'h1111_1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
